// File: rtl/dac_playback_ctrl_pkg.sv
// Shared configuration for the DAC playback controller: default widths and
// the playback state encoding.
package rfsoc_config;

    localparam int DEF_DATA_W = 256;  // 16 samples x 16 bit per DAC beat
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_REP_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PRE  = 2'b01,
        ST_RUN  = 2'b10,
        ST_POST = 2'b11
    } pb_state_e;

endpackage : rfsoc_config

// File: rtl/dac_playback_ctrl_counter.sv
// Loadable down-counter used for the pre/run/post phase lengths and the pass
// count. Saturates at zero; last_o flags the final cycle of a loaded run.
module dac_pass_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // load has priority over decrement; never decrement past zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == W'(1));

endmodule : dac_pass_counter

// File: rtl/dac_playback_ctrl.sv
// DAC playback controller: on trigger, plays run_len beats from the waveform
// FIFO (first/last beats masked), framed by pre/post idle gaps, for reps passes.
// In IDLE it can drive a live locking waveform.
module dac_playback_ctrl
    import rfsoc_config::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [CNT_W-1:0]  cfg_run_len,
    input  logic [CNT_W-1:0]  cfg_pre_delay,
    input  logic [CNT_W-1:0]  cfg_post_delay,
    input  logic [REP_W-1:0]  cfg_reps,
    input  logic [DATA_W-1:0] cfg_mask_first,
    input  logic [DATA_W-1:0] cfg_mask_last,
    input  logic [DATA_W-1:0] cfg_lock_wave,
    input  logic              cfg_lock_en,
    input  logic              trigger_in,
    input  logic              abort_in,
    input  logic              clear_in,
    output logic              loopback_valid,
    output logic              busy,
    output logic              done,
    output logic              underflow,
    output logic              cfg_err,
    output logic              aborted
);

    pb_state_e state_q, state_d;

    // shadow copies of the configuration taken on an accepted trigger
    logic [CNT_W-1:0]  run_len_q, pre_dly_q, post_dly_q;
    logic [DATA_W-1:0] mask_first_q, mask_last_q;

    logic done_q, done_d;
    logic underflow_q, underflow_d;
    logic cfg_err_q, cfg_err_d;
    logic aborted_q, aborted_d;

    logic cap, err_set, abort_set, end_pass;
    logic pre_ld, run_ld, post_ld, rep_ld;
    logic pre_dec, run_dec, post_dec, rep_dec;
    logic pre_last, run_last, post_last, rep_last;
    logic [CNT_W-1:0] pre_val, run_val, run_cnt;
    logic [REP_W-1:0] rep_val;
    logic [CNT_W-1:0] pre_cnt_unused, post_cnt_unused;
    logic [REP_W-1:0] rep_cnt_unused;
    logic             tready_unused;

    // the sink is always ready by construction; its back-pressure is ignored
    assign tready_unused = m_axis_tready;

    // first pass loads from live cfg, later passes reload from the shadows
    assign pre_val = (state_q == ST_IDLE) ? cfg_pre_delay : pre_dly_q;
    assign run_val = (state_q == ST_IDLE) ? cfg_run_len   : run_len_q;
    assign rep_val = (cfg_reps == '0) ? REP_W'(1) : cfg_reps;

    dac_pass_counter #(.W(CNT_W)) u_pre_cnt (
        .clk(clk), .rst(rst), .load_i(pre_ld), .load_val_i(pre_val),
        .dec_i(pre_dec), .cnt_o(pre_cnt_unused), .last_o(pre_last)
    );
    dac_pass_counter #(.W(CNT_W)) u_run_cnt (
        .clk(clk), .rst(rst), .load_i(run_ld), .load_val_i(run_val),
        .dec_i(run_dec), .cnt_o(run_cnt), .last_o(run_last)
    );
    dac_pass_counter #(.W(CNT_W)) u_post_cnt (
        .clk(clk), .rst(rst), .load_i(post_ld), .load_val_i(post_dly_q),
        .dec_i(post_dec), .cnt_o(post_cnt_unused), .last_o(post_last)
    );
    dac_pass_counter #(.W(REP_W)) u_rep_cnt (
        .clk(clk), .rst(rst), .load_i(rep_ld), .load_val_i(rep_val),
        .dec_i(rep_dec), .cnt_o(rep_cnt_unused), .last_o(rep_last)
    );

    // next-state, counter control and flag-set events
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        cap       = 1'b0;
        err_set   = 1'b0;
        abort_set = 1'b0;
        end_pass  = 1'b0;
        pre_ld    = 1'b0;
        run_ld    = 1'b0;
        post_ld   = 1'b0;
        rep_ld    = 1'b0;
        pre_dec   = 1'b0;
        run_dec   = 1'b0;
        post_dec  = 1'b0;
        rep_dec   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger_in) begin
                    if (cfg_run_len == '0) begin
                        err_set = 1'b1;
                    end else begin
                        cap    = 1'b1;
                        rep_ld = 1'b1;
                        if (cfg_pre_delay != '0) begin
                            pre_ld  = 1'b1;
                            state_d = ST_PRE;
                        end else begin
                            run_ld  = 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            ST_PRE: begin
                pre_dec = 1'b1;
                if (pre_last) begin
                    run_ld  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run_dec = 1'b1;
                if (run_last) begin
                    if (post_dly_q != '0) begin
                        post_ld = 1'b1;
                        state_d = ST_POST;
                    end else begin
                        end_pass = 1'b1;
                    end
                end
            end
            ST_POST: begin
                post_dec = 1'b1;
                if (post_last) end_pass = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // pass boundary: either finish or start the next pass from shadows
        if (end_pass) begin
            if (rep_last) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                rep_dec = 1'b1;
                if (pre_dly_q != '0) begin
                    pre_ld  = 1'b1;
                    state_d = ST_PRE;
                end else begin
                    run_ld  = 1'b1;
                    state_d = ST_RUN;
                end
            end
        end

        // abort overrides every other transition and suppresses done
        if (abort_in && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            done_d    = 1'b0;
            abort_set = 1'b1;
        end
    end

    // sticky flags: a set event in the same cycle beats clear_in
    always_comb begin
        underflow_d = ((state_q == ST_RUN) && !s_axis_tvalid) || (underflow_q && !clear_in);
        cfg_err_d   = err_set   || (cfg_err_q && !clear_in);
        aborted_d   = abort_set || (aborted_q && !clear_in);
    end

    // state, done pulse and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
            cfg_err_q   <= cfg_err_d;
            aborted_q   <= aborted_d;
        end
    end

    // configuration shadows, captured only on an accepted trigger
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_len_q    <= '0;
            pre_dly_q    <= '0;
            post_dly_q   <= '0;
            mask_first_q <= '0;
            mask_last_q  <= '0;
        end else if (cap) begin
            run_len_q    <= cfg_run_len;
            pre_dly_q    <= cfg_pre_delay;
            post_dly_q   <= cfg_post_delay;
            mask_first_q <= cfg_mask_first;
            mask_last_q  <= cfg_mask_last;
        end
    end

    // output beat: masked FIFO data in RUN, locking waveform in IDLE, else zero
    always_comb begin
        logic [DATA_W-1:0] mask;
        mask = '1;
        if (run_cnt == run_len_q) mask = mask & mask_first_q;
        if (run_last)             mask = mask & mask_last_q;
        m_axis_tdata = '0;
        if (!rst) begin
            m_axis_tdata = '0;
        end else if (state_q == ST_RUN) begin
            m_axis_tdata = s_axis_tvalid ? (s_axis_tdata & mask) : '0;
        end else if ((state_q == ST_IDLE) && cfg_lock_en) begin
            m_axis_tdata = cfg_lock_wave;
        end
    end

    assign s_axis_tready  = (state_q == ST_RUN);
    assign loopback_valid = s_axis_tready;
    assign m_axis_tvalid  = 1'b1;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign underflow      = underflow_q;
    assign cfg_err        = cfg_err_q;
    assign aborted        = aborted_q;

endmodule : dac_playback_ctrl

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl: stimulus pushes expected output beats
// into a scoreboard queue; a negedge monitor pops one per tready beat.
module tb_dac_playback_ctrl;

    localparam int DW = 64;
    localparam int CW = 16;
    localparam int RW = 8;
    localparam logic [DW-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [CW-1:0] run_len = '0, pre_dly = '0, post_dly = '0;
    logic [RW-1:0] reps = '0;
    logic [DW-1:0] mf = '1, ml = '1, lw = '0;
    logic          lock_en = 1'b0, trig = 1'b0, abrt = 1'b0, clr = 1'b0;
    logic          lb_valid, busy, done, uflow, cerr, abtd;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    int src_idx = 0;
    int beat_no = 0;
    int hole_at = -1;
    int exp_idx = 0;

    always #5 clk = ~clk;

    dac_playback_ctrl #(.DATA_W(DW), .CNT_W(CW), .REP_W(RW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .cfg_run_len(run_len), .cfg_pre_delay(pre_dly), .cfg_post_delay(post_dly),
        .cfg_reps(reps), .cfg_mask_first(mf), .cfg_mask_last(ml),
        .cfg_lock_wave(lw), .cfg_lock_en(lock_en),
        .trigger_in(trig), .abort_in(abrt), .clear_in(clr),
        .loopback_valid(lb_valid), .busy(busy), .done(done),
        .underflow(uflow), .cfg_err(cerr), .aborted(abtd)
    );

    function automatic logic [DW-1:0] src_word(input int i);
        logic [15:0] lo;
        lo = i[15:0];
        return {16'hC0DE, lo, 16'hA5F0, ~lo};
    endfunction

    // waveform FIFO model: one word per accepted beat, optional hole
    assign s_tdata  = src_word(src_idx);
    assign s_tvalid = (beat_no != hole_at);

    always @(posedge clk) begin
        if (s_tready) begin
            beat_no <= beat_no + 1;
            if (s_tvalid) src_idx <= src_idx + 1;
        end
    end

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // queue the expected beats of one pass (only the first 'take' of them)
    task automatic push_pass(input int n, input logic [DW-1:0] fm, input logic [DW-1:0] lm,
                             input int hole, input int take);
        logic [DW-1:0] m;
        for (int b = 0; b < take; b++) begin
            m = '1;
            if (b == 0)     m = m & fm;
            if (b == n - 1) m = m & lm;
            if (b == hole) begin
                exp_q.push_back('0);
            end else begin
                exp_q.push_back(src_word(exp_idx) & m);
                exp_idx++;
            end
        end
    endtask

    // scoreboard monitor: each RUN beat must match the next queued value
    always @(negedge clk) begin : mon
        logic [DW-1:0] e;
        if (s_tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got %h expected no beat", m_tdata);
            end else begin
                e = exp_q.pop_front();
                chkw("beat_data", m_tdata, e);
                chk1("beat_tvalid", m_tvalid, 1'b1);
            end
        end
    end

    initial begin
        // ---- reset values (lock enabled, but reset forces zero) ----
        lock_en = 1'b1;
        lw      = 64'hDEAD_BEEF_0123_4567;
        repeat (3) tick();
        chk1("rst_tready", s_tready, 1'b0);
        chk1("rst_lb", lb_valid, 1'b0);
        chk1("rst_tvalid", m_tvalid, 1'b1);
        chkw("rst_tdata", m_tdata, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_flags", uflow | cerr | abtd, 1'b0);
        rst = 1'b1;
        tick();
        chkw("idle_lock", m_tdata, 64'hDEAD_BEEF_0123_4567);
        lock_en = 1'b0;
        #1 chkw("idle_nolock", m_tdata, '0);

        // ---- 4-beat pass, first-beat low byte masked, cfg changed after trigger ----
        run_len = 16'd4; pre_dly = '0; post_dly = '0; reps = 8'd1;
        mf = 64'hFFFF_FFFF_FFFF_FF00; ml = ONES;
        exp_idx = src_idx;
        push_pass(4, mf, ml, -1, 4);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk1("t1_first_rdy", s_tready, 1'b1);
        chk1("t1_busy", busy, 1'b1);
        mf = '0; run_len = 16'd9; reps = 8'd5;
        repeat (3) begin
            tick();
            chk1("t1_rdy", s_tready, 1'b1);
        end
        tick();
        chk1("t1_rdy_end", s_tready, 1'b0);
        chk1("t1_done", done, 1'b1);
        tick();
        chk1("t1_done_pulse", done, 1'b0);

        // ---- single-beat pass: both masks apply ----
        run_len = 16'd1; reps = 8'd1;
        mf = 64'h0F0F_0F0F_0F0F_0F0F; ml = 64'hF0F0_F0F0_F0F0_F0F0;
        push_pass(1, mf, ml, -1, 1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk1("t2_rdy", s_tready, 1'b1);
        tick();
        chk1("t2_done", done, 1'b1);
        tick();

        // ---- 3 passes of pre=2 / run=3 / post=1, retrigger ignored ----
        run_len = 16'd3; pre_dly = 16'd2; post_dly = 16'd1; reps = 8'd3;
        mf = 64'hFFFF_0000_FFFF_FFFF; ml = 64'hFFFF_FFFF_FFFF_0000;
        repeat (3) push_pass(3, mf, ml, -1, 3);
        trig = 1'b1;
        tick();
        for (int c = 1; c <= 19; c++) begin
            int  p;
            logic er;
            p  = (c - 1) % 6;
            er = (c <= 18) && (p >= 2) && (p <= 4);
            chk1($sformatf("t3_rdy_c%0d", c), s_tready, er);
            chk1($sformatf("t3_done_c%0d", c), done, (c == 19));
            trig = (c == 5);
            if (c == 5) run_len = 16'd7;
            tick();
        end
        chk1("t3_done_once", done, 1'b0);
        chk1("t3_idle", busy, 1'b0);

        // ---- underflow on beat 2 of 4, then clear ----
        run_len = 16'd4; pre_dly = '0; post_dly = '0; reps = 8'd1; mf = ONES; ml = ONES;
        hole_at = beat_no + 1;
        push_pass(4, mf, ml, 1, 4);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (4) tick();
        chk1("t4_uflow", uflow, 1'b1);
        chk1("t4_done", done, 1'b1);
        hole_at = -1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk1("t4_uflow_clr", uflow, 1'b0);

        // ---- abort mid-RUN ----
        run_len = 16'd6; mf = 64'hFFFF_FFFF_FFFF_FF00;
        push_pass(6, mf, ml, -1, 2);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        abrt = 1'b1;
        tick();
        abrt = 1'b0;
        chk1("t5_rdy", s_tready, 1'b0);
        chk1("t5_lb", lb_valid, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_aborted", abtd, 1'b1);
        chk1("t5_no_done", done, 1'b0);
        tick();
        chk1("t5_no_done2", done, 1'b0);

        // ---- zero run length is a config error ----
        run_len = '0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk1("t5_cfg_err", cerr, 1'b1);
        chk1("t5_err_busy", busy, 1'b0);
        tick();
        chk1("t5_err_busy2", busy, 1'b0);
        // set beats clear in the same cycle; other flags do clear
        trig = 1'b1; clr = 1'b1;
        tick();
        trig = 1'b0;
        chk1("t5_err_set_wins", cerr, 1'b1);
        chk1("t5_abort_clr", abtd, 1'b0);
        tick();
        clr = 1'b0;
        chk1("t5_err_clr", cerr, 1'b0);

        // ---- async reset mid-RUN with lock enabled ----
        lock_en = 1'b1; lw = 64'h0123_4567_89AB_CDEF;
        run_len = 16'd5; mf = ONES;
        push_pass(5, mf, ml, -1, 1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk1("t6_rdy", s_tready, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        chk1("t6_rst_rdy", s_tready, 1'b0);
        chk1("t6_rst_lb", lb_valid, 1'b0);
        chkw("t6_rst_tdata", m_tdata, '0);
        chk1("t6_rst_busy", busy, 1'b0);
        chk1("t6_rst_tvalid", m_tvalid, 1'b1);
        tick();
        chk1("t6_rst_done", done, 1'b0);
        rst = 1'b1;
        tick();
        chkw("t6_lock_after", m_tdata, 64'h0123_4567_89AB_CDEF);
        chk1("t6_done_after", done, 1'b0);
        chk1("t6_busy_after", busy, 1'b0);

        tick();
        chkw("sb_empty", 64'(exp_q.size()), '0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dac_playback_ctrl
